// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: ownership state encoding
// and default bus widths.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/bus_mux2.sv
// Combinational owner select onto the shared bus master port.
// Drives all-zero outputs when neither master is selected.
module bus_mux2 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              sel0_i,
    input  logic              sel1_i,
    input  logic              m0_req_i,
    input  logic              m0_wr_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dout_i,
    input  logic              m1_req_i,
    input  logic              m1_wr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dout_i,
    output logic              b_req_o,
    output logic              b_wr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [DATA_W-1:0] b_dout_o
);

    always_comb begin
        b_req_o  = 1'b0;
        b_wr_o   = 1'b0;
        b_addr_o = '0;
        b_dout_o = '0;
        if (sel0_i) begin
            b_req_o  = m0_req_i;
            b_wr_o   = m0_wr_i;
            b_addr_o = m0_addr_i;
            b_dout_o = m0_dout_i;
        end else if (sel1_i) begin
            b_req_o  = m1_req_i;
            b_wr_o   = m1_wr_i;
            b_addr_o = m1_addr_i;
            b_dout_o = m1_dout_i;
        end
    end

endmodule

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter for the shared bus master port, with a hold
// counter that forces a handoff after MAX_HOLD contended cycles.
module bus_arb2
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M1_req,
    input  logic              M0_wr,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M0_addr,
    input  logic [ADDR_W-1:0] M1_addr,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M0_din,
    output logic [DATA_W-1:0] M1_din,
    output logic              B_req,
    output logic              B_wr,
    output logic [ADDR_W-1:0] B_addr,
    output logic [DATA_W-1:0] B_dout,
    input  logic              B_grant,
    input  logic [DATA_W-1:0] B_din
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (M0_req && M1_req) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (M0_req) begin
                    state_d = ST_OWN0;
                end else if (M1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!M0_req) begin
                    state_d = M1_req ? ST_OWN1 : ST_IDLE;
                end else if (M1_req && (hold_q == HOLD_LAST)) begin
                    state_d = ST_OWN1;
                end else begin
                    hold_d = M1_req ? hold_q + HOLD_W'(1) : '0;
                end
            end
            ST_OWN1: begin
                if (!M1_req) begin
                    state_d = M0_req ? ST_OWN0 : ST_IDLE;
                end else if (M0_req && (hold_q == HOLD_LAST)) begin
                    state_d = ST_OWN0;
                end else begin
                    hold_d = M0_req ? hold_q + HOLD_W'(1) : '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase

        // A fresh tenure always starts with a cleared counter.
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == ST_OWN0) begin
                last_d = 1'b0;
            end else if (state_d == ST_OWN1) begin
                last_d = 1'b1;
            end
        end
    end

    assign M0_grant = (state_q == ST_OWN0) & B_grant;
    assign M1_grant = (state_q == ST_OWN1) & B_grant;
    assign M0_din   = B_din;
    assign M1_din   = B_din;

    bus_mux2 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .sel0_i   (state_q == ST_OWN0),
        .sel1_i   (state_q == ST_OWN1),
        .m0_req_i (M0_req),
        .m0_wr_i  (M0_wr),
        .m0_addr_i(M0_addr),
        .m0_dout_i(M0_dout),
        .m1_req_i (M1_req),
        .m1_wr_i  (M1_wr),
        .m1_addr_i(M1_addr),
        .m1_dout_i(M1_dout),
        .b_req_o  (B_req),
        .b_wr_o   (B_wr),
        .b_addr_o (B_addr),
        .b_dout_o (B_dout)
    );

endmodule

// File: tb/tb_bus_arb2.sv
// Self-checking bench for bus_arb2: directed scenarios with literal expectations
// plus a randomized run checked every cycle against an owner-level model.
module tb_bus_arb2;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          M0_req, M1_req, M0_wr, M1_wr;
    logic [AW-1:0] M0_addr, M1_addr;
    logic [DW-1:0] M0_dout, M1_dout;
    logic          M0_grant, M1_grant;
    logic [DW-1:0] M0_din, M1_din;
    logic          B_req, B_wr;
    logic [AW-1:0] B_addr;
    logic [DW-1:0] B_dout;
    logic          B_grant;
    logic [DW-1:0] B_din;

    int checks   = 0;
    int failures = 0;

    bus_arb2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M1_req(M1_req), .M0_wr(M0_wr), .M1_wr(M1_wr),
        .M0_addr(M0_addr), .M1_addr(M1_addr), .M0_dout(M0_dout), .M1_dout(M1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant), .M0_din(M0_din), .M1_din(M1_din),
        .B_req(B_req), .B_wr(B_wr), .B_addr(B_addr), .B_dout(B_dout),
        .B_grant(B_grant), .B_din(B_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner-level model: who owns the bus (-1 none), who owned last, and how many
    // cycles the current owner has already kept the bus while the other waited.
    typedef struct packed {
        int   own;
        logic last;
        int   ten;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_next(mstate_t s, logic r0, logic r1);
        mstate_t    n;
        logic [1:0] r;
        int         o;
        n = s;
        r = {r1, r0};
        o = s.own;
        if (o < 0) begin
            if (r0 && r1)  n.own = s.last ? 0 : 1;
            else if (r0)   n.own = 0;
            else if (r1)   n.own = 1;
        end else if (!r[o]) begin
            n.own = r[1-o] ? 1 - o : -1;
        end else if (r[1-o]) begin
            n.ten = s.ten + 1;
            if (n.ten >= MH) n.own = 1 - o;
        end else begin
            n.ten = 0;
        end
        if (n.own != o) begin
            n.ten = 0;
            if (n.own >= 0) n.last = (n.own == 1);
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) ms <= '{own: -1, last: 1'b1, ten: 0};
        else       ms <= model_next(ms, M0_req, M1_req);
    end

    always @(negedge clk) begin
        logic          e_req, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dout;
        e_req  = 1'b0;
        e_wr   = 1'b0;
        e_addr = '0;
        e_dout = '0;
        if (ms.own == 0) begin
            e_req = M0_req; e_wr = M0_wr; e_addr = M0_addr; e_dout = M0_dout;
        end else if (ms.own == 1) begin
            e_req = M1_req; e_wr = M1_wr; e_addr = M1_addr; e_dout = M1_dout;
        end
        chk("m_M0_grant", M0_grant, (ms.own == 0) && B_grant);
        chk("m_M1_grant", M1_grant, (ms.own == 1) && B_grant);
        chk("m_B_req", B_req, e_req);
        chk("m_B_wr", B_wr, e_wr);
        chk("m_B_addr", B_addr, e_addr);
        chk("m_B_dout", B_dout, e_dout);
        chk("m_M0_din", M0_din, B_din);
        chk("m_M1_din", M1_din, B_din);
    end

    initial begin
        int wait1, max_wait1;
        reset = 1'b0;
        M0_req = 0; M1_req = 0; M0_wr = 0; M1_wr = 0;
        M0_addr = '0; M1_addr = '0; M0_dout = '0; M1_dout = '0;
        B_grant = 1'b1; B_din = '0;
        #1 reset = 1'b1;
        repeat (2) tick();

        // reset state
        chk("rst_M0_grant", M0_grant, 0);
        chk("rst_M1_grant", M1_grant, 0);
        chk("rst_B_req", B_req, 0);
        chk("rst_B_wr", B_wr, 0);
        chk("rst_B_addr", B_addr, 0);
        chk("rst_B_dout", B_dout, 0);
        reset = 1'b0;

        // single master write
        M1_req = 1; M1_wr = 1; M1_addr = 8'h05; M1_dout = 32'hDEADBEEF;
        #1 chk("single_grant_before_edge", M1_grant, 0);
        tick();
        chk("single_M1_grant", M1_grant, 1);
        chk("single_M0_grant", M0_grant, 0);
        chk("single_B_addr", B_addr, 8'h05);
        chk("single_B_dout", B_dout, 32'hDEADBEEF);
        chk("single_B_wr", B_wr, 1);
        M1_req = 0; M1_wr = 0;
        tick();
        chk("single_release_grant", M1_grant, 0);
        chk("single_release_B_req", B_req, 0);

        // first tie after reset goes to M0, gapless handoff, next tie to M0 again
        reset = 1'b1;
        #1 reset = 1'b0;
        M0_req = 1; M1_req = 1;
        tick();
        chk("tie_M0_grant", M0_grant, 1);
        chk("tie_M1_grant", M1_grant, 0);
        M0_req = 0;
        tick();
        chk("handoff_M1_grant", M1_grant, 1);
        chk("handoff_M0_grant", M0_grant, 0);
        M1_req = 0;
        tick();
        M0_req = 1; M1_req = 1;
        tick();
        chk("tie2_M0_grant", M0_grant, 1);

        // continuous contention: ownership alternates every MH cycles
        wait1 = 0;
        max_wait1 = 0;
        for (int i = 0; i < 4 * MH; i++) begin
            chk("starve_M0_grant", M0_grant, ((i / MH) % 2) == 0);
            chk("starve_M1_grant", M1_grant, ((i / MH) % 2) == 1);
            if (!M1_grant) wait1++;
            else wait1 = 0;
            if (wait1 > max_wait1) max_wait1 = wait1;
            tick();
        end
        chk("starve_M1_max_wait", max_wait1, MH);

        // bus grant low holds off the master grant but not the bus request
        M0_req = 0; M1_req = 0;
        tick();
        B_grant = 0; M0_req = 1; M0_wr = 0; M0_addr = 8'h10;
        tick();
        chk("bgrant_low_M0_grant", M0_grant, 0);
        chk("bgrant_low_B_req", B_req, 1);
        chk("bgrant_low_B_addr", B_addr, 8'h10);
        B_grant = 1;
        #1 chk("bgrant_high_M0_grant", M0_grant, 1);

        // read data broadcast to both masters
        M0_addr = 8'h20; B_din = 32'h0000_0042;
        #1;
        chk("bcast_M0_din", M0_din, 32'h0000_0042);
        chk("bcast_M1_din", M1_din, 32'h0000_0042);
        chk("bcast_M0_grant", M0_grant, 1);
        chk("bcast_M1_grant", M1_grant, 0);

        // asynchronous reset while M0 owns
        reset = 1'b1;
        #1;
        chk("async_rst_M0_grant", M0_grant, 0);
        chk("async_rst_B_req", B_req, 0);
        chk("async_rst_B_addr", B_addr, 0);
        tick();
        reset = 1'b0; M1_req = 1;
        #1 chk("after_rst_idle_grant", M0_grant | M1_grant, 0);
        tick();
        chk("after_rst_tie_M0", M0_grant, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) M0_req = ~M0_req;
            if ($urandom_range(0, 5) == 0) M1_req = ~M1_req;
            M0_wr   = $urandom_range(0, 1);
            M1_wr   = $urandom_range(0, 1);
            M0_addr = AW'($urandom);
            M1_addr = AW'($urandom);
            M0_dout = $urandom;
            M1_dout = $urandom;
            B_din   = $urandom;
            B_grant = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
